// File: rtl/wrb_dec_arb.sv
// Round-robin arbiter sharing the writeback->decode register-file write channel among NREQ sources.
// Optional build macro WRB_DEC_ARB_R0_FILTER_EN drops granted packets whose rd is x0.
module wrb_dec_arb #(
  parameter int NREQ  = 3,
  parameter int PKT_W = 37,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*PKT_W-1:0] req_pkt,
  output logic [NREQ-1:0]       req_rdy,
  output logic                  wrb_dec_vld,
  output logic [PKT_W-1:0]      wrb_dec_pkt,
  output logic [CNT_W-1:0]      wrb_conflict_cnt,
  input  logic                  cnt_clr
);

  localparam int LG_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [LG_W-1:0]  r_last_grant;
  logic             r_vld;
  logic [PKT_W-1:0] r_pkt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic [LG_W-1:0]  w_gnt_idx;
  logic [LG_W-1:0]  w_idx;
  logic [NREQ-1:0]  w_gnt;
  logic [PKT_W-1:0] w_sel_pkt;
  logic             w_fwd;
  logic             w_multi;

  // Search starts one past the last winner and wraps, so every requester is reached within NREQ slots.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = r_last_grant;
    w_idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = LG_W'((int'(r_last_grant) + k) % NREQ);
      if (!w_any && req_vld[w_idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
  end

  always_comb begin
    w_gnt     = '0;
    w_sel_pkt = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt[i] = w_any && (w_gnt_idx == LG_W'(i));
      if (w_gnt[i]) w_sel_pkt = req_pkt[i*PKT_W +: PKT_W];
    end
  end

`ifdef WRB_DEC_ARB_R0_FILTER_EN
  // Writes to x0 are consumed here so decode never sees them.
  assign w_fwd = w_any && (w_sel_pkt[PKT_W-1 -: 5] != 5'd0);
`else
  assign w_fwd = w_any;
`endif

  // Clearing the lowest set bit leaves a nonzero vector exactly when two or more are set.
  assign w_multi = |(req_vld & (req_vld - NREQ'(1)));

  assign req_rdy = resetn ? w_gnt : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld        <= 1'b0;
      r_pkt        <= '0;
      r_cnt        <= '0;
      r_last_grant <= LG_W'(NREQ - 1);
    end else begin
      r_vld <= w_fwd;
      if (w_fwd) r_pkt <= w_sel_pkt;
      if (w_any) r_last_grant <= w_gnt_idx;
      if (cnt_clr)
        r_cnt <= '0;
      else if (w_multi && !(&r_cnt))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign wrb_dec_vld      = r_vld;
  assign wrb_dec_pkt      = r_pkt;
  assign wrb_conflict_cnt = r_cnt;

endmodule

// File: tb/tb_wrb_dec_arb.sv
// Scoreboard bench for wrb_dec_arb: stimulus pushes expected writebacks, a negedge monitor pops and compares.
module tb_wrb_dec_arb;

  localparam int NREQ  = 3;
  localparam int PKT_W = 37;
  localparam int CNT_W = 4;

  logic                  clk;
  logic                  resetn;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*PKT_W-1:0] req_pkt;
  logic [NREQ-1:0]       req_rdy;
  logic                  wrb_dec_vld;
  logic [PKT_W-1:0]      wrb_dec_pkt;
  logic [CNT_W-1:0]      wrb_conflict_cnt;
  logic                  cnt_clr;

  logic [PKT_W-1:0] pk [NREQ];

  typedef struct {
    int               cyc;
    logic [PKT_W-1:0] pkt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc;
  int   n_tests;
  int   n_fail;

  wrb_dec_arb #(.NREQ(NREQ), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .req_vld          (req_vld),
    .req_pkt          (req_pkt),
    .req_rdy          (req_rdy),
    .wrb_dec_vld      (wrb_dec_vld),
    .wrb_dec_pkt      (wrb_dec_pkt),
    .wrb_conflict_cnt (wrb_conflict_cnt),
    .cnt_clr          (cnt_clr)
  );

  assign req_pkt = {pk[2], pk[1], pk[0]};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus: er is the hand-computed grant, ec the counter value visible this cycle.
  task automatic step(input logic [2:0] v, input logic clr, input logic [2:0] er,
                      input logic [3:0] ec, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    req_vld = v;
    cnt_clr = clr;
    #2;
    chk({nm, "_rdy"}, 64'(req_rdy), 64'(er));
    chk({nm, "_cnt"}, 64'(wrb_conflict_cnt), 64'(ec));
    for (int i = 0; i < NREQ; i++) begin
      if (er[i]) begin
`ifdef WRB_DEC_ARB_R0_FILTER_EN
        if (pk[i][PKT_W-1 -: 5] != 5'd0) begin
          x.cyc = cyc + 1;
          x.pkt = pk[i];
          q.push_back(x);
        end
`else
        x.cyc = cyc + 1;
        x.pkt = pk[i];
        q.push_back(x);
`endif
      end
    end
  endtask

  // Monitor: every presented writeback must match the oldest expectation and arrive in its cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (wrb_dec_vld === 1'b1) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL out_spurious: got vld=1 pkt=%0h at cycle %0d, expected no writeback", wrb_dec_pkt, cyc);
        end else begin
          e = q.pop_front();
          chk("out_pkt", 64'(wrb_dec_pkt), 64'(e.pkt));
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL out_missing: got vld=%b at cycle %0d, expected pkt %0h", wrb_dec_vld, cyc, e.pkt);
      end
    end
  end

  initial begin
    logic [2:0] er;
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    cnt_clr = 1'b0;
    req_vld = 3'b111;
    pk[0] = {5'd1, 32'h1111_0000};
    pk[1] = {5'd2, 32'h2222_0000};
    pk[2] = {5'd3, 32'h3333_0000};

    // Reset held with all requesters valid
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rdy", 64'(req_rdy), 64'h0);
    chk("rst_vld", 64'(wrb_dec_vld), 64'h0);
    chk("rst_cnt", 64'(wrb_conflict_cnt), 64'h0);
    chk("rst_pkt", 64'(wrb_dec_pkt), 64'h0);
    @(posedge clk);
    #1;
    req_vld = 3'b000;
    resetn  = 1'b1;

    step(3'b111, 1'b0, 3'b001, 4'd0, "t1_first");
    step(3'b000, 1'b1, 3'b000, 4'd1, "t1_clr");

    // Single requester
    pk[1] = {5'd4, 32'hDEADBEEF};
    step(3'b010, 1'b0, 3'b010, 4'd0, "t2_single");
    step(3'b000, 1'b0, 3'b000, 4'd0, "t2_idle");
    pk[1] = {5'd2, 32'h2222_0000};

    // Re-align last grant to 2, then all valid for 6 cycles
    step(3'b100, 1'b0, 3'b100, 4'd0, "t3_align");
    for (int k = 0; k < 6; k++) begin
      er = 3'b001 << (k % 3);
      step(3'b111, 1'b0, er, 4'(k), "t3_rot");
    end
    step(3'b000, 1'b0, 3'b000, 4'd6, "t3_cnt6");

    // Idle gap does not reset the rotation
    step(3'b010, 1'b0, 3'b010, 4'd6, "t4_g1");
    for (int k = 0; k < 3; k++) step(3'b000, 1'b0, 3'b000, 4'd6, "t4_idle");
    step(3'b111, 1'b0, 3'b100, 4'd6, "t4_after");
    step(3'b000, 1'b1, 3'b000, 4'd7, "t4_clr");

    // Counter saturation then clear-beats-increment
    for (int k = 0; k < 20; k++) begin
      er = (k % 2 == 0) ? 3'b001 : 3'b010;
      step(3'b011, 1'b0, er, (k >= 15) ? 4'hF : 4'(k), "t5_sat");
    end
    step(3'b000, 1'b0, 3'b000, 4'hF, "t5_hold");
    step(3'b111, 1'b1, 3'b100, 4'hF, "t5_clrwin");
    step(3'b000, 1'b0, 3'b000, 4'd0, "t5_cleared");

    // rd == x0 packet from requester 0
    pk[0] = {5'd0, 32'h0000_0001};
    step(3'b001, 1'b0, 3'b001, 4'd0, "t6_rd0");
    step(3'b000, 1'b0, 3'b000, 4'd0, "t6_idle");
    step(3'b000, 1'b0, 3'b000, 4'd0, "t6_idle2");

    @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
